hazard_ctrl: RTL

Pipeline hazard controller: the stall/flush side of the operand-bypass network. For every dependence the bypass muxes cannot cover, it freezes PC and IF/ID, injects a bubble into ID/EX, and flushes IF/ID on taken branches resolved in ID. A small stall FSM holds multi-cycle stalls without re-detection, and an external memory-wait freezes the whole pipe.

---
 rtl/hazard_ctrl_pkg.sv | 23 ++
 rtl/hazard_ctrl_if.sv | 41 ++++
 rtl/hazard_ctrl_perf.sv | 20 ++
 rtl/hazard_ctrl.sv | 131 +++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline package: register address width, stall FSM state type,
// debug view of the FSM, and the stall-length constants.
package pipe_pkg;

  localparam int NREG_W = 3;

  // Bubble counts for the dependences the bypass network cannot cover.
  localparam logic [1:0] STALL_LOAD    = 2'd1;
  localparam logic [1:0] STALL_BR_LOAD = 2'd2;
  localparam logic [1:0] STALL_BR_ALU  = 2'd1;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } hz_state_t;

  // Debug view of the stall FSM so checkers can observe it directly.
  typedef struct packed {
    hz_state_t  state;
    logic [1:0] remain;
  } hz_dbg_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: ID/EX/MEM hazard inputs from the pipeline (master)
// and the PC/IF-ID/ID-EX control outputs back to it (slave = controller).
// All signals are level-sampled every cycle; there is no handshake, the
// controller's outputs are a pure function of its state and this cycle's
// inputs, and the pipeline must honour them in the same cycle.
interface hazard_ctrl_if #(
  parameter int NREG_W = 3
);
  import pipe_pkg::*;

  logic [NREG_W-1:0] rs1;
  logic [NREG_W-1:0] rs2;
  logic              rs1Used;
  logic              rs2Used;
  logic              BranchID;
  logic              BranchTaken;
  logic [NREG_W-1:0] rdEX;
  logic              RegWriteEX;
  logic              MemReadEX;
  logic [NREG_W-1:0] rdMEM;
  logic              MemReadMEM;
  logic              MemWait;
  logic              PCWrite;
  logic              IFIDWrite;
  logic              BubbleEX;
  logic              FlushIF;
  hz_dbg_t           dbg;

  modport master (
    output rs1, rs2, rs1Used, rs2Used, BranchID, BranchTaken,
           rdEX, RegWriteEX, MemReadEX, rdMEM, MemReadMEM, MemWait,
    input  PCWrite, IFIDWrite, BubbleEX, FlushIF, dbg
  );

  modport slave (
    input  rs1, rs2, rs1Used, rs2Used, BranchID, BranchTaken,
           rdEX, RegWriteEX, MemReadEX, rdMEM, MemReadMEM, MemWait,
    output PCWrite, IFIDWrite, BubbleEX, FlushIF, dbg
  );

endinterface

// File: rtl/hazard_ctrl_perf.sv
// Saturating event counter used for the hazard performance statistics.
module hazard_perf #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count qualified events, holding at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: freezes PC/IF-ID and bubbles ID/EX for
// dependences the bypass cannot cover, flushes IF/ID on taken ID branches,
// and freezes everything under MemWait.
// Optional feature macro: HAZARD_PERF_EN adds three saturating counters.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int NREG_W = pipe_pkg::NREG_W
`ifdef HAZARD_PERF_EN
  ,
  parameter int PERF_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  hazard_ctrl_if.slave      bus
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0] stallCnt,
  output logic [PERF_W-1:0] brStallCnt,
  output logic [PERF_W-1:0] flushCnt
`endif
);

  hz_state_t  state;
  logic [1:0] remain;
  logic [1:0] need;
  logic [1:0] need1;
  logic [1:0] need2;
  logic       stall;

  // Stall length demanded by one source register of the ID instruction.
  function automatic logic [1:0] src_len(
    input logic              used,
    input logic [NREG_W-1:0] r,
    input logic              branch,
    input logic [NREG_W-1:0] rd_ex,
    input logic              wr_ex,
    input logic              load_ex,
    input logic [NREG_W-1:0] rd_mem,
    input logic              load_mem
  );
    logic       m_ex;
    logic       m_mem;
    logic [1:0] len;
    m_ex  = (r != '0) && (r == rd_ex) && wr_ex;
    m_mem = (r != '0) && (r == rd_mem) && load_mem;
    len   = 2'd0;
    if (used) begin
      if (branch) begin
        if (m_ex && load_ex)      len = STALL_BR_LOAD;
        else if (m_ex || m_mem)   len = STALL_BR_ALU;
      end else if (m_ex && load_ex) begin
        len = STALL_LOAD;
      end
    end
    return len;
  endfunction

  // Required stall length: maximum over both participating sources.
  always_comb begin
    need1 = src_len(bus.rs1Used, bus.rs1, bus.BranchID, bus.rdEX,
                    bus.RegWriteEX, bus.MemReadEX, bus.rdMEM, bus.MemReadMEM);
    need2 = src_len(bus.rs2Used, bus.rs2, bus.BranchID, bus.rdEX,
                    bus.RegWriteEX, bus.MemReadEX, bus.rdMEM, bus.MemReadMEM);
    need  = (need1 > need2) ? need1 : need2;
  end

  // HOLD keeps the stall without re-detection, so a frozen ID instruction
  // cannot re-trigger once its operands are on their way.
  assign stall = ((state == RUN) && (need != 2'd0)) || (state == HOLD);

  // Pipeline control; reset forces the pipe clear, MemWait masks all else.
  always_comb begin
    bus.PCWrite   = !rst && !stall && !bus.MemWait;
    bus.IFIDWrite = !rst && !stall && !bus.MemWait;
    bus.BubbleEX  = rst || (stall && !bus.MemWait);
    bus.FlushIF   = rst || (bus.BranchTaken && bus.BranchID && !stall && !bus.MemWait);
  end

  // Stall FSM: RUN detects and launches a stall, HOLD counts remaining bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      remain <= 2'd0;
    end else if (!bus.MemWait) begin
      case (state)
        RUN: begin
          if (need != 2'd0) begin
            remain <= need - 2'd1;
            state  <= (need > 2'd1) ? HOLD : RUN;
          end
        end
        HOLD: begin
          remain <= remain - 2'd1;
          if (remain <= 2'd1) state <= RUN;
        end
        default: begin
          state  <= RUN;
          remain <= 2'd0;
        end
      endcase
    end
  end

  assign bus.dbg = '{state: state, remain: remain};

`ifdef HAZARD_PERF_EN
  logic act;
  assign act = !rst && !bus.MemWait;

  hazard_perf #(.W(PERF_W)) u_stall_cnt (
    .clk (clk), .rst (rst),
    .inc (act && stall && !bus.BranchID),
    .cnt (stallCnt)
  );

  hazard_perf #(.W(PERF_W)) u_br_stall_cnt (
    .clk (clk), .rst (rst),
    .inc (act && stall && bus.BranchID),
    .cnt (brStallCnt)
  );

  hazard_perf #(.W(PERF_W)) u_flush_cnt (
    .clk (clk), .rst (rst),
    .inc (act && bus.FlushIF),
    .cnt (flushCnt)
  );
`endif

endmodule
